// File: rtl/trace_buffer.sv
// trace_buffer: captures packed N-lane vectors from the data packer into a
// circular buffer while tracing, then drains them oldest-first to the host
// readout path. The capture policy (circular overwrite or stop-when-full) is
// programmed over the shared configId/configData bus.
// Optional macro TRACE_BUFFER_TIMESTAMP_EN adds a per-entry cycle timestamp
// and the timestamp_out port.
module trace_buffer #(
   parameter int N                  = 8,
   parameter int DATA_WIDTH         = 32,
   parameter int BUFFER_SIZE        = 4,
   parameter int PERSONAL_CONFIG_ID = 0,
   parameter int INITIAL_MODE       = 0
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 tracing,
   input  logic                                 valid_in,
   input  logic [N-1:0][DATA_WIDTH-1:0]         vector_in,
   input  logic [7:0]                           configId,
   input  logic [7:0]                           configData,
   input  logic                                 read_req,
   output logic [N-1:0][DATA_WIDTH-1:0]         vector_out,
   output logic                                 valid_out,
   output logic [$clog2(BUFFER_SIZE):0]         count,
   output logic                                 overflow
`ifdef TRACE_BUFFER_TIMESTAMP_EN
   ,
   output logic [31:0]                          timestamp_out
`endif
);

   localparam int PW = $clog2(BUFFER_SIZE);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(BUFFER_SIZE);
   localparam logic [PW-1:0] PTR_ONE    = PW'(1);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [7:0]    MY_ID      = 8'(PERSONAL_CONFIG_ID);

   typedef enum logic {
      READOUT = 1'b0,
      CAPTURE = 1'b1
   } state_t;

   state_t                        state_q, state_d;
   logic [PW-1:0]                 wrPtr_q, wrPtr_d;
   logic [PW-1:0]                 rdPtr_q, rdPtr_d;
   logic [CW-1:0]                 count_q, count_d;
   logic                          overflow_q, overflow_d;
   logic                          mode_q, mode_d;
   logic [7:0]                    cfgCnt_q, cfgCnt_d;
   logic [N-1:0][DATA_WIDTH-1:0]  vectorOut_q;
   logic                          validOut_q;

   logic                          memWe;
   logic [PW-1:0]                 memAddr;
   logic                          popEn;

   logic [N-1:0][DATA_WIDTH-1:0]  mem_q [BUFFER_SIZE];

`ifdef TRACE_BUFFER_TIMESTAMP_EN
   logic [31:0]                   cycleCnt_q;
   logic [31:0]                   tsMem_q [BUFFER_SIZE];
   logic [31:0]                   timestamp_q;
`endif

   // Next-state logic: the tracing input selects capture or readout behaviour.
   // The first tracing cycle opens a new session, and a write in that same
   // cycle lands in entry 0 of the freshly cleared buffer.
   always_comb begin
      state_d    = state_q;
      wrPtr_d    = wrPtr_q;
      rdPtr_d    = rdPtr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      mode_d     = mode_q;
      cfgCnt_d   = cfgCnt_q;
      memWe      = 1'b0;
      memAddr    = wrPtr_q;
      popEn      = 1'b0;
      if (tracing) begin
         state_d = CAPTURE;
         if (state_q == READOUT) begin
            wrPtr_d    = '0;
            rdPtr_d    = '0;
            count_d    = '0;
            overflow_d = 1'b0;
         end
         if (valid_in) begin
            if (count_d < FULL_COUNT) begin
               memWe   = 1'b1;
               memAddr = wrPtr_d;
               wrPtr_d = wrPtr_d + PTR_ONE;
               count_d = count_d + CNT_ONE;
            end else if (mode_q == 1'b0) begin
               memWe      = 1'b1;
               memAddr    = wrPtr_d;
               wrPtr_d    = wrPtr_d + PTR_ONE;
               rdPtr_d    = rdPtr_d + PTR_ONE;
               overflow_d = 1'b1;
            end else begin
               overflow_d = 1'b1;
            end
         end
      end else begin
         state_d = READOUT;
         if (read_req && (count_q != '0)) begin
            popEn   = 1'b1;
            rdPtr_d = rdPtr_q + PTR_ONE;
            count_d = count_q - CNT_ONE;
         end
         // The byte counter saturates so a long-held id never re-arms byte 0.
         if (configId == MY_ID) begin
            if (cfgCnt_q == 8'd0) begin
               mode_d = configData[0];
            end
            if (cfgCnt_q != 8'hFF) begin
               cfgCnt_d = cfgCnt_q + 8'd1;
            end
         end else begin
            cfgCnt_d = 8'd0;
         end
      end
   end

   // Control registers and registered outputs, all cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= READOUT;
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         mode_q      <= (INITIAL_MODE != 0);
         cfgCnt_q    <= 8'd0;
         vectorOut_q <= '0;
         validOut_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         mode_q     <= mode_d;
         cfgCnt_q   <= cfgCnt_d;
         validOut_q <= popEn;
         if (popEn) begin
            vectorOut_q <= mem_q[rdPtr_q];
         end
      end
   end

   // Data storage has no reset; an empty count keeps stale entries unreadable.
   always_ff @(posedge clk) begin
      if (memWe && !reset) begin
         mem_q[memAddr] <= vector_in;
      end
   end

`ifdef TRACE_BUFFER_TIMESTAMP_EN
   // Free-running cycle counter, timestamp storage and the timestamp output.
   always_ff @(posedge clk) begin
      if (reset) begin
         cycleCnt_q  <= 32'd0;
         timestamp_q <= 32'd0;
      end else begin
         cycleCnt_q <= cycleCnt_q + 32'd1;
         if (memWe) begin
            tsMem_q[memAddr] <= cycleCnt_q;
         end
         if (popEn) begin
            timestamp_q <= tsMem_q[rdPtr_q];
         end
      end
   end

   assign timestamp_out = timestamp_q;
`endif

   assign vector_out = vectorOut_q;
   assign valid_out  = validOut_q;
   assign count      = count_q;
   assign overflow   = overflow_q;

endmodule
